// File: rtl/outcollect.sv
// outcollect: retires per-channel FPU results in strict issue order via an issue-tag FIFO.
// Latency: ch_done at t -> buffer valid t+1 -> out_valid t+2; out_* hold while out_valid && !out_ready.
// Optional OUTCOLLECT_OVF_STICKY_EN adds ovf_sticky/ovf_clr.
module outcollect #(
    parameter int WIDTH     = 32,
    parameter int NCH       = 3,
    parameter int TAG_DEPTH = 4,
    localparam int TW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [TW-1:0]        issue_tag,
    output logic                 issue_ready,
    input  logic [NCH*WIDTH-1:0] ch_result,
    input  logic [NCH-1:0]       ch_done,
    input  logic [NCH-1:0]       ch_overflow,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_overflow,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef OUTCOLLECT_OVF_STICKY_EN
    output logic                 ovf_sticky,
    input  logic                 ovf_clr,
`endif
    output logic                 err
);

    localparam int AW = $clog2(TAG_DEPTH);

    logic [TW-1:0]    tag_mem [TAG_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic [TW-1:0]    head_tag;
    logic             tag_ok;
    logic             push_ok;
    logic             push_err;

    logic [WIDTH-1:0] buf_dat [NCH];
    logic [NCH-1:0]   buf_ovf;
    logic [NCH-1:0]   buf_vld;

    logic             sel_vld;
    logic             sel_ovf;
    logic [WIDTH-1:0] sel_dat;
    logic [NCH-1:0]   clr_vec;
    logic             retire;
    logic             dbl_err;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign issue_ready = !full;
    assign head_tag    = tag_mem[rd_ptr[AW-1:0]];
    assign tag_ok      = int'(issue_tag) < NCH;
    assign push_ok     = issue_valid && !full && tag_ok;
    assign push_err    = issue_valid && (full || !tag_ok);

    always_comb begin
        sel_vld = 1'b0;
        sel_ovf = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < NCH; k++) begin
            if (head_tag == TW'(k)) begin
                sel_vld = buf_vld[k];
                sel_ovf = buf_ovf[k];
                sel_dat = buf_dat[k];
            end
        end
    end

    assign retire = !empty && sel_vld && (!out_valid || out_ready);

    always_comb begin
        clr_vec = '0;
        for (int k = 0; k < NCH; k++) begin
            clr_vec[k] = retire && (head_tag == TW'(k));
        end
    end

    // A done on a full buffer is only legal if that buffer is draining this cycle.
    assign dbl_err = |(ch_done & buf_vld & ~clr_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            buf_vld      <= '0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_valid    <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (push_ok) begin
                tag_mem[wr_ptr[AW-1:0]] <= issue_tag;
                wr_ptr                  <= wr_ptr + 1'b1;
            end
            if (retire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            for (int k = 0; k < NCH; k++) begin
                if (ch_done[k] && (!buf_vld[k] || clr_vec[k])) begin
                    buf_dat[k] <= ch_result[k*WIDTH +: WIDTH];
                    buf_ovf[k] <= ch_overflow[k];
                    buf_vld[k] <= 1'b1;
                end else if (clr_vec[k]) begin
                    buf_vld[k] <= 1'b0;
                end
            end

            if (retire) begin
                out_result   <= sel_dat;
                out_overflow <= sel_ovf;
                out_valid    <= 1'b1;
            end else if (out_ready) begin
                out_valid    <= 1'b0;
            end

            if (push_err || dbl_err) begin
                err <= 1'b1;
            end
        end
    end

`ifdef OUTCOLLECT_OVF_STICKY_EN
    // Set has priority over clear so a same-cycle overflow is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (retire && sel_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_outcollect.sv
// Scoreboard bench for outcollect: expected results queued in issue order, monitor pops on each transfer.
module tb_outcollect;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [1:0]  issue_tag;
    logic        issue_ready;
    logic [95:0] ch_result;
    logic [2:0]  ch_done;
    logic [2:0]  ch_overflow;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_valid;
    logic        out_ready;
    logic        err;
`ifdef OUTCOLLECT_OVF_STICKY_EN
    logic        ovf_sticky;
    logic        ovf_clr;
`endif

    int total = 0;
    int bad   = 0;
    logic [32:0] sb [$];

    outcollect #(.WIDTH(32), .NCH(3), .TAG_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_tag   (issue_tag),
        .issue_ready (issue_ready),
        .ch_result   (ch_result),
        .ch_done     (ch_done),
        .ch_overflow (ch_overflow),
        .out_result  (out_result),
        .out_overflow(out_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef OUTCOLLECT_OVF_STICKY_EN
        .ovf_sticky  (ovf_sticky),
        .ovf_clr     (ovf_clr),
`endif
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {31'd0, out_overflow, out_result}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("out_data", {31'd0, out_overflow, out_result}, {31'd0, sb.pop_front()});
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input logic [31:0] val, input logic ovf);
        sb.push_back({ovf, val});
    endtask

    task automatic push(input int tag);
        issue_valid = 1'b1;
        issue_tag   = 2'(tag);
        step();
        issue_valid = 1'b0;
    endtask

    task automatic done(input int ch, input logic [31:0] val, input logic ovf);
        ch_result[ch*32 +: 32] = val;
        ch_done[ch]            = 1'b1;
        ch_overflow[ch]        = ovf;
        step();
        ch_done     = '0;
        ch_overflow = '0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) step();
        step(2);
        chk({"drain_", name}, 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_tag   = '0;
        ch_result   = '0;
        ch_done     = '0;
        ch_overflow = '0;
        out_ready   = 1'b1;
`ifdef OUTCOLLECT_OVF_STICKY_EN
        ovf_clr     = 1'b0;
`endif
        step(2);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        step();

        // In-order across channels: mul issued first, add completes first and must wait.
        expect_res(32'h4000_0000, 1'b0);
        expect_res(32'h3F80_0000, 1'b0);
        push(1);
        push(0);
        done(0, 32'h3F80_0000, 1'b0);
        step(2);
        chk("order_wait_no_out", 64'(out_valid), 64'd0);
        done(1, 32'h4000_0000, 1'b0);
        drain("order");
        chk("order_err", 64'(err), 64'd0);

        // Pointer wrap: push and retire every cycle, one retire per cycle steady state.
        for (int i = 0; i <= 20; i++) begin
            issue_valid = (i < 20);
            issue_tag   = 2'(i % 3);
            ch_done     = '0;
            ch_overflow = '0;
            if (i < 20) expect_res(32'hA000_0000 + 32'(i), 1'(i % 2));
            if (i > 0) begin
                ch_done[(i-1) % 3]             = 1'b1;
                ch_overflow[(i-1) % 3]         = 1'((i-1) % 2);
                ch_result[((i-1) % 3)*32 +: 32] = 32'hA000_0000 + 32'(i-1);
            end
            step();
        end
        issue_valid = 1'b0;
        ch_done     = '0;
        ch_overflow = '0;
        drain("wrap");
        chk("wrap_err", 64'(err), 64'd0);

        // Full FIFO and output backpressure.
        do_reset();
        out_ready = 1'b0;
        push(0);
        push(1);
        push(2);
        push(0);
        chk("full_issue_ready", 64'(issue_ready), 64'd0);
        chk("full_err_before", 64'(err), 64'd0);
        push(1);
        chk("full_err_after", 64'(err), 64'd1);
        expect_res(32'h1111_1111, 1'b0);
        expect_res(32'h2222_2222, 1'b0);
        expect_res(32'h3333_3333, 1'b0);
        expect_res(32'h4444_4444, 1'b0);
        done(0, 32'h1111_1111, 1'b0);
        done(1, 32'h2222_2222, 1'b0);
        step(3);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_data", 64'(out_result), 64'h1111_1111);
        done(2, 32'h3333_3333, 1'b0);
        done(0, 32'h4444_4444, 1'b0);
        chk("bp_still_held", 64'(out_result), 64'h1111_1111);
        out_ready = 1'b1;
        drain("backpressure");

        // Double done on channel 1: the first (overflowing) result survives.
        do_reset();
        done(1, 32'h0000_0005, 1'b1);
        done(1, 32'h0000_0006, 1'b0);
        chk("dbl_err", 64'(err), 64'd1);
        expect_res(32'h0000_0005, 1'b1);
        push(1);
        drain("double");
`ifdef OUTCOLLECT_OVF_STICKY_EN
        chk("ovf_sticky_set", 64'(ovf_sticky), 64'd1);
        step(2);
        chk("ovf_sticky_hold", 64'(ovf_sticky), 64'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_sticky_clr", 64'(ovf_sticky), 64'd0);
`endif

        // Reset mid-traffic: held output and buffered result must vanish.
        do_reset();
        out_ready = 1'b0;
        expect_res(32'h0000_0077, 1'b0);
        expect_res(32'h0000_0088, 1'b0);
        push(0);
        done(0, 32'h0000_0077, 1'b0);
        push(1);
        done(1, 32'h0000_0088, 1'b0);
        rst = 1'b1;
        step(2);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_result", 64'(out_result), 64'd0);
        chk("mid_rst_out_ovf", 64'(out_overflow), 64'd0);
        chk("mid_rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("mid_rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        expect_res(32'h0000_00AA, 1'b0);
        expect_res(32'h0000_0099, 1'b0);
        push(1);
        push(2);
        done(2, 32'h0000_0099, 1'b0);
        step(2);
        done(1, 32'h0000_00AA, 1'b0);
        drain("post_reset");
        chk("post_reset_err", 64'(err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
